// File: rtl/stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd
//
// Purpose
//   Turns rising edges of the divided lab clock (tick_clk_i) into one-cycle
//   ticks in the clk_i domain and counts them in an NDIGITS-digit BCD counter.
//   The counter is controlled by start/stop/clear and drives the display logic.
//
// Parameters
//   NDIGITS      number of BCD digits (count range 0 .. 10^NDIGITS-1)
//   SYNC_STAGES  synchronizer depth on tick_clk_i (must be >= 2)
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   tick_clk_i   divided clock to be edge-detected
//   start_i      level, enter/resume RUN
//   stop_i       level, RUN -> PAUSE
//   clear_i      level, any state -> IDLE and count zeroed
//   lap_i        capture current count into lap_bcd_o
//   bcd_o        count, digit 0 in bits [3:0]
//   lap_bcd_o    captured lap value
//   running_o    high while in RUN
//   tick_o       one-cycle pulse per rising edge of tick_clk_i
//   wrap_o       one-cycle pulse when the count wraps from all 9s to 0
//
// Configuration
//   STOPWATCH_LAP_EN  when defined, lap capture is built; otherwise lap_i is
//                     ignored and lap_bcd_o is constant zero.
// -----------------------------------------------------------------------------
module stopwatch_bcd #(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_clk_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 clear_i,
  input  logic                 lap_i,
  output logic [4*NDIGITS-1:0] bcd_o,
  output logic [4*NDIGITS-1:0] lap_bcd_o,
  output logic                 running_o,
  output logic                 tick_o,
  output logic                 wrap_o
);

  localparam int unsigned W = 4 * NDIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizer and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick_q;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // prev_q resets to 0, so a tick_clk_i that is already high at reset release
  // is seen as a rising edge and produces exactly one tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_clk_i};
      prev_q <= sync_last;
      tick_q <= sync_last & ~prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   running_q, running_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (clear_i)      state_d = S_IDLE;
        else if (stop_i)  state_d = S_IDLE;
        else if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (clear_i)      state_d = S_IDLE;
        else if (stop_i)  state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (clear_i)      state_d = S_IDLE;
        else if (stop_i)  state_d = S_PAUSE;
        else if (start_i) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
    end
  end

  // ---------------------------------------------------------------------------
  // BCD counter
  // ---------------------------------------------------------------------------
  logic [W-1:0] bcd_q, bcd_d;
  logic [W-1:0] bcd_inc;
  logic         carry;
  logic         inc_en;
  logic         wrap_q, wrap_d;

  // Ripple +1 across the digits; the carry out of the top digit is only set
  // when every digit was 9, which is exactly the wrap condition.
  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int unsigned d = 0; d < NDIGITS; d++) begin
      if (carry) begin
        if (bcd_q[4*d +: 4] == 4'd9) begin
          bcd_inc[4*d +: 4] = 4'd0;
          carry             = 1'b1;
        end else begin
          bcd_inc[4*d +: 4] = bcd_q[4*d +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Counting uses the registered state, so a tick coinciding with stop_i is
  // still counted; clear_i overrides any same-cycle increment.
  always_comb begin
    inc_en = (state_q == S_RUN) && tick_q;
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (clear_i) begin
      bcd_d = '0;
    end else if (inc_en) begin
      bcd_d  = bcd_inc;
      wrap_d = carry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lap capture
  // ---------------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap_q, lap_d;

  // Captures the count as it stands before any same-cycle increment.
  always_comb begin
    lap_d = lap_q;
    if (clear_i) begin
      lap_d = '0;
    end else if (lap_i && (state_q != S_IDLE)) begin
      lap_d = bcd_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign lap_bcd_o = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap_i;
  assign lap_bcd_o  = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bcd_o     = bcd_q;
  assign running_o = running_q;
  assign tick_o    = tick_q;
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

  localparam int ND   = 4;
  localparam int W    = 4 * ND;
  localparam int MAXV = 10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick_clk = 1'b0;
  logic         start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [W-1:0] bcd, lap_bcd;
  logic         running, tick, wrap;

  always #5 clk = ~clk;

  stopwatch_bcd #(.NDIGITS(ND), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .tick_clk_i (tick_clk),
    .start_i    (start),
    .stop_i     (stop),
    .clear_i    (clear),
    .lap_i      (lap),
    .bcd_o      (bcd),
    .lap_bcd_o  (lap_bcd),
    .running_o  (running),
    .tick_o     (tick),
    .wrap_o     (wrap)
  );

  typedef struct {
    logic [W-1:0] bcd;
    logic         wrap;
    logic         run;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: decimal count, state (0 idle, 1 run, 2 pause), lap value.
  int m = 0;
  int mstate = 0;
  int mlap = 0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one cycle after every tick_o pulse, compare against the scoreboard.
  bit   pending = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
    end else begin
      if (pending) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tick: got tick with empty queue, required none");
        end else begin
          mon_e = sb.pop_front();
          chk("tick_bcd", bcd, mon_e.bcd);
          chk("tick_wrap", {15'd0, wrap}, {15'd0, mon_e.wrap});
          chk("tick_run", {15'd0, running}, {15'd0, mon_e.run});
        end
      end
      pending = (tick === 1'b1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_ctl(input bit s, input bit p, input bit c, input bit l);
    if (c) begin
      mstate = 0; m = 0; mlap = 0;
    end else begin
`ifdef STOPWATCH_LAP_EN
      if (l && mstate != 0) mlap = m;
`endif
      if (p) begin
        if (mstate == 1) mstate = 2;
      end else if (s) begin
        mstate = 1;
      end
    end
  endtask

  task automatic ctl(input bit s, input bit p, input bit c, input bit l);
    model_ctl(s, p, c, l);
    start = s; stop = p; clear = c; lap = l;
    @(negedge clk);
    start = 0; stop = 0; clear = 0; lap = 0;
  endtask

  function automatic exp_t mk(input int v, input bit w, input bit r);
    exp_t e;
    e.bcd = to_bcd(v);
    e.wrap = w;
    e.run = r;
    return e;
  endfunction

  task automatic tick_exp();
    bit w;
    w = 0;
    if (mstate == 1) begin
      m = (m + 1) % MAXV;
      w = (m == 0);
    end
    sb.push_back(mk(m, w, mstate == 1));
    tick_clk = 1;
    @(negedge clk);
    tick_clk = 0;
    @(negedge clk);
  endtask

  // Issue a tick and apply control inputs in the very cycle tick_o is high.
  task automatic tick_with_ctl(input bit s, input bit p, input bit c);
    bit w;
    int n;
    w = 0;
    if (c) m = 0;
    else if (mstate == 1) begin
      m = (m + 1) % MAXV;
      w = (m == 0);
    end
    model_ctl(s, p, c, 0);
    sb.push_back(mk(m, w, mstate == 1));
    tick_clk = 1;
    @(negedge clk);
    tick_clk = 0;
    n = 0;
    while (tick !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL tick_wait: got no tick within 10 cycles, required tick");
    end
    start = s; stop = p; clear = c;
    @(negedge clk);
    start = 0; stop = 0; clear = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || pending) && n < 20) begin
      @(negedge clk);
      n++;
    end
    cyc(1);
    chk("drain_empty", W'(sb.size()), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    // Reset state
    cyc(3);
    rst_n = 1;
    cyc(1);
    chk("rst_bcd", bcd, '0);
    chk("rst_lap", lap_bcd, '0);
    chk("rst_run", {15'd0, running}, '0);
    chk("rst_tick", {15'd0, tick}, '0);
    chk("rst_wrap", {15'd0, wrap}, '0);

    // Edge latency: tick_o exactly 3 cycles after the rise, one wide
    ctl(1, 0, 0, 0);
    chk("start_run", {15'd0, running}, 16'd1);
    m = 1;
    sb.push_back(mk(1, 0, 1));
    tick_clk = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("latency_c%0d", k), {15'd0, tick}, (k == 3) ? 16'd1 : 16'd0);
    end
    cyc(2);
    tick_clk = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (tick === 1'b1) seen = 1;
    end
    chk("no_fall_tick", {15'd0, seen}, '0);
    drain();

    // Control: pause freezes, resume counts, clear+start goes idle
    repeat (4) tick_exp();
    drain();
    ctl(0, 1, 0, 0);
    chk("pause_run", {15'd0, running}, '0);
    repeat (3) tick_exp();
    drain();
    chk("pause_hold", bcd, 16'h0005);
    ctl(1, 0, 0, 0);
    tick_exp();
    drain();
    ctl(1, 0, 1, 0);
    chk("clr_start_bcd", bcd, '0);
    chk("clr_start_run", {15'd0, running}, '0);

    // Simultaneous tick with stop, then with clear
    ctl(1, 0, 0, 0);
    repeat (7) tick_exp();
    drain();
    tick_with_ctl(0, 1, 0);
    repeat (2) tick_exp();
    drain();
    chk("stop_tick_frozen", bcd, 16'h0008);
    ctl(1, 0, 0, 0);
    tick_with_ctl(0, 0, 1);
    drain();
    chk("clr_tick_bcd", bcd, '0);

    // Lap capture, 0099->0100 carry, full wrap
    ctl(1, 0, 0, 0);
    while (m < 123) tick_exp();
    drain();
    ctl(0, 0, 0, 1);
    chk("lap_capture", lap_bcd, to_bcd(mlap));
    repeat (50) tick_exp();
    drain();
    chk("lap_hold", lap_bcd, to_bcd(mlap));
    chk("count_173", bcd, 16'h0173);
    while (m != MAXV - 1) tick_exp();
    drain();
    chk("all_nines", bcd, 16'h9999);
    tick_exp();
    drain();
    chk("wrap_one_cycle", {15'd0, wrap}, '0);
    chk("wrap_still_run", {15'd0, running}, 16'd1);
    ctl(0, 0, 1, 0);
    chk("clear_lap", lap_bcd, '0);
    ctl(0, 0, 0, 1);
    chk("idle_lap_ignored", lap_bcd, '0);

    // Reset mid-count at 0x0042, tick_clk held high across release
    ctl(1, 0, 0, 0);
    repeat (42) tick_exp();
    drain();
    ctl(0, 0, 0, 1);
    chk("pre_rst_bcd", bcd, 16'h0042);
    tick_clk = 1;
    #2;
    rst_n = 0;
    #1;
    chk("arst_bcd", bcd, '0);
    chk("arst_lap", lap_bcd, '0);
    chk("arst_run", {15'd0, running}, '0);
    chk("arst_tick", {15'd0, tick}, '0);
    chk("arst_wrap", {15'd0, wrap}, '0);
    sb.delete();
    m = 0; mstate = 0; mlap = 0;
    sb.push_back(mk(0, 0, 0));
    cyc(3);
    rst_n = 1;
    cyc(6);
    tick_clk = 0;
    drain();
    ctl(1, 0, 0, 0);
    tick_exp();
    drain();
    chk("post_rst_count", bcd, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
